// File: rtl/iob2axi_wr_burst_ctrl.sv
// Splits one linear write transfer into AXI4 INCR bursts (<= MAX_BURST beats, no 4 KB crossing)
// and sequences them through the write engine, accumulating engine error status.
module iob2axi_wr_burst_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int AXI_LEN_W = 8,
   parameter int MAX_BURST = 256,
   parameter int CNT_W     = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [CNT_W-1:0]     total_len,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 eng_run,
   output logic [ADDR_W-1:0]    eng_addr,
   output logic [AXI_LEN_W-1:0] eng_length,
   input  logic                 eng_ready,
   input  logic                 eng_error
);

   localparam int BYTES  = DATA_W / 8;
   localparam int BSHIFT = $clog2(BYTES);
   localparam int BW     = CNT_W + 1;
   localparam int MW     = (BW > 14) ? BW : 14;

   typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cur_addr;
   logic [CNT_W-1:0]    rem;
   logic [CNT_W-1:0]    beats;
   logic [12:0]         page_bytes;
   logic [MW-1:0]       page_left;
   logic [MW-1:0]       beats_w;
   logic [CNT_W-1:0]    rem_next;
   logic [ADDR_W-1:0]   addr_step;

   function automatic logic [MW-1:0] umin3(input logic [MW-1:0] a,
                                           input logic [MW-1:0] b,
                                           input logic [MW-1:0] c);
      logic [MW-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   // Beats left before the next 4 KB page; never 0 because cur_addr is BYTES-aligned.
   always_comb begin
      page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
      page_left  = MW'(page_bytes >> BSHIFT);
      beats_w    = umin3(MW'(rem), MW'(MAX_BURST), page_left);
      rem_next   = rem - beats;
      addr_step  = ADDR_W'(beats) << BSHIFT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_addr   <= '0;
         rem        <= '0;
         beats      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         eng_run    <= 1'b0;
         eng_addr   <= '0;
         eng_length <= '0;
      end else begin
         done    <= 1'b0;
         eng_run <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  if (total_len != '0) begin
                     cur_addr <= base_addr;
                     rem      <= total_len;
                     busy     <= 1'b1;
                     state    <= CALC;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            CALC: begin
               beats      <= CNT_W'(beats_w);
               eng_addr   <= cur_addr;
               eng_length <= AXI_LEN_W'(beats_w - MW'(1));
               state      <= ISSUE;
            end
            ISSUE: begin
               if (eng_ready) begin
                  eng_run <= 1'b1;
                  state   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!eng_ready) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (eng_ready) begin
                  error    <= error | eng_error;
                  cur_addr <= cur_addr + addr_step;
                  rem      <= rem_next;
                  if (rem_next == '0) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob2axi_wr_burst_ctrl.sv
// Directed bench: stimulus pushes expected bursts/done events, a monitor pops and compares,
// and a small engine model answers each eng_run.
module tb_iob2axi_wr_burst_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [19:0] total_len;
   logic        busy, done, error, eng_run;
   logic [31:0] eng_addr;
   logic [7:0]  eng_length;
   logic        eng_ready, eng_error;

   iob2axi_wr_burst_ctrl #(
      .ADDR_W(32), .DATA_W(32), .AXI_LEN_W(8), .MAX_BURST(256), .CNT_W(20)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_len(total_len),
      .busy(busy), .done(done), .error(error), .eng_run(eng_run), .eng_addr(eng_addr),
      .eng_length(eng_length), .eng_ready(eng_ready), .eng_error(eng_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_t;

   burst_t exp_bq[$];
   logic   exp_dq[$];
   int     checks = 0;
   int     errors = 0;
   int     burst_idx = 0;
   int     err_burst = -1;
   int     eng_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
      burst_t b;
      b.addr = a;
      b.len  = l;
      exp_bq.push_back(b);
   endtask

   // Engine model: drops ready after a run pulse, holds busy a few cycles, then reports.
   initial begin
      eng_ready = 1'b1;
      eng_error = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            eng_ready = 1'b1;
            eng_cnt   = 0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               eng_error = (burst_idx == err_burst);
               burst_idx++;
               eng_ready = 1'b1;
            end
         end else if (eng_run) begin
            eng_ready = 1'b0;
            eng_cnt   = 2 + (burst_idx % 3);
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      burst_t b;
      logic   e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (eng_run && done) begin
               checks++; errors++;
               $display("FAIL run_done_overlap actual=1 expected=0");
            end
            if (eng_run) begin
               if (exp_bq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_run addr=%0h len=%0h", eng_addr, eng_length);
               end else begin
                  b = exp_bq.pop_front();
                  check("burst_addr", eng_addr, b.addr);
                  check("burst_len", {24'd0, eng_length}, {24'd0, b.len});
               end
            end
            if (done) begin
               if (exp_dq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done actual=1 expected=0");
               end else begin
                  e = exp_dq.pop_front();
                  check("done_error", {31'd0, error}, {31'd0, e});
                  check("done_busy", {31'd0, busy}, 32'd0);
               end
            end
         end
      end
   end

   task automatic start_xfer(input logic [31:0] a, input logic [19:0] n);
      base_addr = a;
      total_len = n;
      burst_idx = 0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_bq.size() != 0 || exp_dq.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL %s_timeout actual=%0d expected=<5000", name, n);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; total_len = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_run", {31'd0, eng_run}, 32'd0);
      check("rst_addr", eng_addr, 32'd0);
      check("rst_len", {24'd0, eng_length}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single burst
      push_burst(32'h1000, 8'd15); exp_dq.push_back(1'b0);
      start_xfer(32'h1000, 20'd16);
      check("single_busy", {31'd0, busy}, 32'd1);
      wait_drain("single");

      // 600 words split by MAX_BURST, with a start pulse while busy that must be ignored
      push_burst(32'h0, 8'd255); push_burst(32'h400, 8'd255); push_burst(32'h800, 8'd87);
      exp_dq.push_back(1'b0);
      start_xfer(32'h0, 20'd600);
      repeat (5) @(negedge clk);
      base_addr = 32'h5000; total_len = 20'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain("split600");

      // 4 KB page split
      push_burst(32'h0FF0, 8'd3); push_burst(32'h1000, 8'd5); exp_dq.push_back(1'b0);
      start_xfer(32'h0FF0, 20'd10);
      wait_drain("page_split");

      // Address wrap across 2**ADDR_W
      push_burst(32'hFFFF_FFF0, 8'd3); push_burst(32'h0, 8'd3); exp_dq.push_back(1'b0);
      start_xfer(32'hFFFF_FFF0, 20'd8);
      wait_drain("wrap");

      // Engine error on burst 2 is sticky until the next accepted start
      err_burst = 1;
      push_burst(32'h0, 8'd255); push_burst(32'h400, 8'd255); push_burst(32'h800, 8'd87);
      exp_dq.push_back(1'b1);
      start_xfer(32'h0, 20'd600);
      wait_drain("err600");
      err_burst = -1;
      repeat (3) @(negedge clk);
      check("error_sticky", {31'd0, error}, 32'd1);
      push_burst(32'h2000, 8'd3); exp_dq.push_back(1'b0);
      start_xfer(32'h2000, 20'd4);
      check("error_cleared", {31'd0, error}, 32'd0);
      wait_drain("after_err");

      // Zero-length start
      exp_dq.push_back(1'b0);
      start_xfer(32'h7000, 20'd0);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      wait_drain("zero");

      // Reset while burst 2 is in WAIT_DONE
      err_burst = 0;
      push_burst(32'h0, 8'd255); push_burst(32'h400, 8'd255); push_burst(32'h800, 8'd87);
      exp_dq.push_back(1'b1);
      start_xfer(32'h0, 20'd600);
      begin
         int n = 0;
         while (!(burst_idx == 1 && eng_cnt > 0) && n < 5000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 5000) begin
            errors++;
            $display("FAIL rst_wait_timeout actual=%0d expected=<5000", n);
         end
      end
      @(negedge clk);
      check("pre_rst_error", {31'd0, error}, 32'd1);
      check("pre_rst_pending", exp_bq.size(), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_run", {31'd0, eng_run}, 32'd0);
      check("midrst_error", {31'd0, error}, 32'd0);
      check("midrst_addr", eng_addr, 32'd0);
      exp_bq.delete();
      exp_dq.delete();
      err_burst = -1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_burst(32'h3000, 8'd7); exp_dq.push_back(1'b0);
      start_xfer(32'h3000, 20'd8);
      wait_drain("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iob2axi_wr_burst_ctrl.md
Name: iob2axi_wr_burst_ctrl

Overview:
- Sequencer in front of the AXI write engine (run/addr/length/ready/error control interface).
- Accepts one long linear write transfer (start byte address + total word count) and splits it into legal AXI4 INCR bursts.
- Burst limits: at most MAX_BURST beats, and no burst crosses a 4 KB boundary. Issues each burst to the engine, waits for completion, and accumulates the error status across bursts.
- Sits between the DMA/register front-end and the write engine; the data path (s_valid/s_wdata) bypasses this block.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; BYTES = DATA_W/8, power of 2, at least 1
AXI_LEN_W, 8, engine length field width
MAX_BURST, 256, max beats per burst, at most 2**AXI_LEN_W
CNT_W, 20, width of total word count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  start pulse; sampled only in IDLE
base_addr  in  ADDR_W  first byte address, BYTES-aligned
total_len  in  CNT_W  number of words to write
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
error  out  1  sticky OR of per-burst engine errors; cleared on accepted start
eng_run  out  1  one-cycle run pulse to engine
eng_addr  out  ADDR_W  burst start address
eng_length  out  AXI_LEN_W  burst beats minus 1
eng_ready  in  1  engine idle
eng_error  in  1  engine error of last completed burst

Behaviour:
- Reset values: busy=0, done=0, error=0, eng_run=0, eng_addr=0, eng_length=0. State=IDLE, internal addr and remaining count cleared.
- States: IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - On start with total_len != 0: latch cur_addr=base_addr and rem=total_len, clear error, set busy=1, go to CALC.
  - On start with total_len == 0: done pulses next cycle, error cleared, busy stays 0, no eng_run.
- CALC (1 cycle):
  - page_left = (4096 - cur_addr[11:0]) / BYTES.
  - beats = min(rem, MAX_BURST, page_left).
  - Register eng_addr=cur_addr and eng_length=beats-1 (truncated to AXI_LEN_W). Go to ISSUE.
- ISSUE:
  - Wait for eng_ready=1, then assert eng_run for exactly one cycle.
  - eng_addr/eng_length are held stable from CALC until the WAIT_DONE exit.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Wait for eng_ready=0 (engine accepted). eng_run is 0 here.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On eng_ready=1: error |= eng_error; cur_addr += beats*BYTES; rem -= beats.
  - If the new rem == 0: done=1 for one cycle, busy=0, go to IDLE. Otherwise go to CALC.
- Latency: start-to-first eng_run is 2 cycles when eng_ready=1. Between bursts there are 2 cycles from eng_ready rise to the next eng_run.
- Arithmetic:
  - beats is computed at CNT_W+1 bits; the min is unsigned.
  - cur_addr wraps modulo 2**ADDR_W with no error.
  - page_left is never 0, since addresses are BYTES-aligned.
- start while busy is ignored. Parameters are latched at start, so input changes mid-transfer have no effect.
- An async rst mid-transfer returns to IDLE with all outputs at reset values. An engine burst in flight is not tracked; the engine is reset by the same rst.
- done and eng_run are never high in the same cycle.

Test Plan:
- base_addr=0x1000, total_len=16, DATA_W=32 -> one eng_run, eng_addr=0x1000, eng_length=15; done after eng_ready returns; error=0.
- base_addr=0x0, total_len=600 -> bursts at 0x0 (len 255), 0x400 (255), 0x800 (87); one done pulse.
- base_addr=0x0FF0, total_len=10 -> burst 0x0FF0 len 3, then 0x1000 len 5 (4 KB split).
- total_len=600, eng_error=1 only on burst 2 -> error=1 after done and stays 1; next start clears it to 0.
- total_len=0 start -> no eng_run, done pulse 1 cycle later, busy stays 0. Start pulsed while busy -> ignored.
- rst asserted during WAIT_DONE of burst 2 -> busy=0, eng_run=0, error=0 immediately; a new start begins from the new base_addr.
